// File: rtl/ps2_host_tx_if.sv
// Command handshake between the host logic and the PS/2 transmitter.
// The slave modport is the transmitter; the master is whoever supplies bytes.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 frame transmitter over open-collector clk/data lines.
// The device clock is synchronised and glitch-filtered, never used as a clock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, ready for a byte
// INHIBIT   | host holds clk low; start bit asserted on exit
// RELEASE   | clk released, start bit on data, waiting for first fall
// SEND      | presenting data/parity/stop on each fall
// ACK       | next fall samples the device ack on data
// WAIT_IDLE | waiting for both lines high before reporting done
// ERR       | one-cycle error report, lines released
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE, S_ERR
  } state_t;

  state_t        state, state_n;
  logic [1:0]    clk_meta, dat_meta;
  logic          clk_sync, dat_sync;
  logic          clk_filt, clk_filt_d, fall;
  logic [FW-1:0] flt_cnt;
  logic [9:0]    shreg, shreg_n;
  logic [3:0]    idx, idx_n;
  logic          dat_q, dat_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] to_cnt, to_n;
  logic          to_expired;

  assign clk_sync = clk_meta[1];
  assign dat_sync = dat_meta[1];

  // Synchronisers reset high so a reset never fakes a falling edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_meta   <= 2'b11;
      dat_meta   <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_meta   <= {clk_meta[0], ps2_clk_in};
      dat_meta   <= {dat_meta[0], ps2_dat_in};
      clk_filt_d <= clk_filt;
      if (clk_sync == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      idx     <= '0;
      dat_q   <= 1'b0;
      inh_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      dat_q   <= dat_n;
      inh_cnt <= inh_n;
      to_cnt  <= to_n;
    end
  end

  assign to_expired = (to_cnt == '0);

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    idx_n    = idx;
    dat_n    = dat_q;
    inh_n    = inh_cnt;
    to_n     = to_cnt;
    bus.done = 1'b0;
    bus.err  = 1'b0;
    case (state)
      S_IDLE: begin
        dat_n = 1'b0;
        if (bus.tx_valid) begin
          shreg_n = {1'b1, ~^bus.tx_data, bus.tx_data};
          idx_n   = '0;
          inh_n   = IW'(INHIBIT_CYCLES - 1);
          to_n    = '0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == '0) begin
          dat_n   = 1'b1;
          to_n    = TW'(TIMEOUT_CYCLES - 1);
          state_n = S_RELEASE;
        end else begin
          inh_n = inh_cnt - 1'b1;
        end
      end
      S_RELEASE, S_SEND, S_ACK: begin
        if (to_expired) begin
          dat_n   = 1'b0;
          state_n = S_ERR;
        end else begin
          to_n = to_cnt - 1'b1;
          if (fall) begin
            case (state)
              S_RELEASE: begin
                dat_n   = ~shreg[0];
                idx_n   = 4'd1;
                state_n = S_SEND;
              end
              S_SEND: begin
                dat_n = ~shreg[idx];
                if (idx == 4'd9) state_n = S_ACK;
                else             idx_n   = idx + 4'd1;
              end
              default: begin
                dat_n   = 1'b0;
                state_n = dat_sync ? S_ERR : S_WAIT_IDLE;
              end
            endcase
          end
        end
      end
      S_WAIT_IDLE: begin
        dat_n = 1'b0;
        if (clk_sync && dat_sync) begin
          bus.done = 1'b1;
          state_n  = S_IDLE;
        end else if (to_expired) begin
          state_n = S_ERR;
        end else begin
          to_n = to_cnt - 1'b1;
        end
      end
      S_ERR: begin
        bus.err = 1'b1;
        dat_n   = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        dat_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign ps2_clk_oe   = (state == S_INHIBIT);
  assign ps2_dat_oe   = dat_q;
  assign bus.tx_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-collector PS/2 device model.
// Timing parameters are shortened so every scenario fits in a few thousand cycles.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int FLT = 4;
  localparam int TO  = 1000;
  localparam int HP  = 20;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_dat  = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe;
  wire  ps2_clk_in = dev_clk & ~ps2_clk_oe;
  wire  ps2_dat_in = dev_dat & ~ps2_dat_oe;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic both_seen = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bus        (bus),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.err)  err_cnt  <= err_cnt + 1;
    if (bus.done && bus.err) both_seen <= 1'b1;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
  endtask

  // Device side: waits for the host to release clk, then clocks n falls.
  // bits[i] is the data line level just before fall i+1.
  task automatic dev_frame(input int n, input bit ack, output logic [10:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && w < 400) begin
      @(negedge CLOCK_50);
      w++;
    end
    checks++;
    if (w >= 400) begin
      errors++;
      $display("FAIL dev_release actual=no_release required=release_within_400");
      return;
    end
    repeat (30) @(negedge CLOCK_50);
    for (int i = 0; i < n; i++) begin
      bits[i] = ps2_dat_in;
      if (i == 10 && ack) begin
        dev_dat = 1'b0;
        repeat (4) @(negedge CLOCK_50);
      end
      dev_clk = 1'b0;
      repeat (HP) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (HP) @(negedge CLOCK_50);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
      @(negedge CLOCK_50);
      w++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b required=1", bus.tx_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe actual=%b required=00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if ({bus.done, bus.err} !== 2'b00) begin errors++; $display("FAIL reset_pulses actual=%b required=00", {bus.done, bus.err}); end
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready actual=%b required=1", bus.tx_ready); end
  endtask

  task automatic test_send_ed;
    int n, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n !== INH) begin errors++; $display("FAIL inhibit_len actual=%0d required=%0d", n, INH); end
    dev_frame(11, 1'b1, bits);
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL ed_bits actual=%h required=7da", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ed_done actual=%0d required=%0d", done_cnt - d0, 1); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL ed_err actual=%0d required=0", err_cnt - e0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ed_busy actual=%b required=0", bus.busy); end
  endtask

  task automatic test_parity_ignore;
    int d0, e0;
    logic stray;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h01);
    repeat (2) @(negedge CLOCK_50);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hAA;
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL busy_ready actual=%b required=0", bus.tx_ready); end
    repeat (3) @(negedge CLOCK_50);
    bus.tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits);
    checks++; if (bits !== 11'h402) begin errors++; $display("FAIL x01_bits actual=%h required=402", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL x01_done actual=%0d required=1", done_cnt - d0); end
    stray = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK_50);
      if (bus.busy !== 1'b0 || ps2_clk_oe !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL ignored_aa actual=activity required=idle"); end
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF);
    dev_frame(11, 1'b1, bits);
    checks++; if (bits !== 11'h7FE) begin errors++; $display("FAIL xff_bits actual=%h required=7fe", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL xff_done actual=%0d required=1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int n, w, d0;
    d0 = done_cnt;
    send_byte(8'h3C);
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && w < 100) begin
      @(negedge CLOCK_50);
      w++;
    end
    n = 0;
    while (bus.err !== 1'b1 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++; if (n !== TO) begin errors++; $display("FAIL timeout_cycles actual=%0d required=%0d", n, TO); end
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe actual=%b required=00", {ps2_clk_oe, ps2_dat_oe}); end
    @(negedge CLOCK_50);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready actual=%b required=1", bus.tx_ready); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL timeout_done actual=%0d required=0", done_cnt - d0); end
  endtask

  task automatic test_no_ack;
    int d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h55);
    dev_frame(11, 1'b0, bits);
    checks++; if (bits !== 11'h6AA) begin errors++; $display("FAIL x55_bits actual=%h required=6aa", bits); end
    wait_end(d0, e0);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL noack_err actual=%0d required=1", err_cnt - e0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL noack_done actual=%0d required=0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, e0;
    logic [10:0] bits;
    send_byte(8'hE0);
    dev_frame(5, 1'b1, bits);
    checks++; if (ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL bit4_oe actual=%b required=1", ps2_dat_oe); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL async_reset_oe actual=%b required=00", {ps2_clk_oe, ps2_dat_oe}); end
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checks++; if ({bus.tx_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL reset_idle actual=%b required=10", {bus.tx_ready, bus.busy}); end
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    dev_frame(11, 1'b1, bits);
    checks++; if (bits !== 11'h5E8) begin errors++; $display("FAIL xf4_bits actual=%h required=5e8", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt !== d0 + 1 || err_cnt !== e0) begin errors++; $display("FAIL xf4_done actual=%0d/%0d required=1/0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    @(negedge CLOCK_50);
    test_reset;
    test_send_ed;
    test_parity_ignore;
    test_timeout;
    test_no_ack;
    test_reset_mid_frame;
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL done_err_overlap actual=1 required=0"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
